// File: rtl/sum_pkg.sv
// Shared types and defaults for the sum-frame accumulator datapath.
package sum_pkg;

    localparam int SUM_DATA_W = 8;
    localparam int SUM_COUNT  = 4;
    localparam int SUM_ACC_W  = 2 * SUM_DATA_W;

    typedef enum logic [1:0] {
        ACCUM,
        EMIT_HI,
        EMIT_LO
    } acc_state_t;

endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit adder that clamps to all-ones on carry out and reports the clamp.
module sat_adder
    import sum_pkg::*;
#(
    parameter int W = SUM_ACC_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        ovf = raw[W];
        sum = raw[W] ? '1 : raw[W-1:0];
    end

endmodule

// File: rtl/sum_frame_accumulator.sv
// Accumulates COUNT input samples into a saturating 2*DATA_W total and emits it
// as two bytes (high first) with a per-frame sticky overflow flag.
module sum_frame_accumulator
    import sum_pkg::*;
#(
    parameter int DATA_W = SUM_DATA_W,
    parameter int COUNT  = SUM_COUNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_ovf
);

    localparam int ACC_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    acc_state_t state, state_next;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             res_ovf;
    logic             add_carry;
    logic             accept;
    logic             frame_done;

    assign in_ext = ACC_W'(in_data);

    sat_adder #(
        .W(ACC_W)
    ) u_sat_adder (
        .a  (acc),
        .b  (in_ext),
        .sum(acc_sum),
        .ovf(add_carry)
    );

    // in_ready is kept out of the FSM process so accept never feeds back into it.
    assign in_ready   = (state == ACCUM) && !clear && !reset;
    assign accept     = in_valid && in_ready;
    assign frame_done = accept && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_ovf    = 1'b0;
        out_data   = '0;
        case (state)
            ACCUM: begin
                if (frame_done) begin
                    state_next = EMIT_HI;
                end
            end
            EMIT_HI: begin
                out_valid = 1'b1;
                out_data  = result[ACC_W-1:DATA_W];
                out_ovf   = res_ovf;
                if (out_ready) begin
                    state_next = EMIT_LO;
                end
            end
            EMIT_LO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = result[DATA_W-1:0];
                out_ovf   = res_ovf;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            result  <= '0;
            res_ovf <= 1'b0;
        end else begin
            if (state == ACCUM) begin
                if (clear) begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end else if (frame_done) begin
                    result  <= acc_sum;
                    res_ovf <= ovf | add_carry;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                end else if (accept) begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                    ovf <= ovf | add_carry;
                end
            end
            if (state == EMIT_LO && out_ready) begin
                res_ovf <= 1'b0;
            end
        end
    end

endmodule
